// File: rtl/simt_scheduler.sv
// -----------------------------------------------------------------------------
// simt_scheduler
//
// Per-block SIMT control scheduler. Each thread lane keeps its own PC and a
// finished flag, so lanes may diverge on branches. Every instruction issues at
// the minimum PC over live lanes; the lanes sitting at that PC form the active
// mask. Because the scheduler always picks the lowest PC, diverged lanes
// reconverge when they arrive at the same PC.
//
// Optional feature (macro SIMT_DIVERGENCE_STATS_EN):
//   When defined, adds the diverge_count output. It counts the UPDATE steps
//   that issue a mask narrower than the full set of live lanes, saturating at
//   16'hFFFF. When undefined, the port and the counter are absent.
//
// Ports:
//   clk                      clock
//   reset                    synchronous, active-high reset
//   start                    launch block (sampled only in IDLE)
//   thread_count             live threads, clamped to THREADS_PER_BLOCK
//   fetch_valid              fetcher holds a valid instruction
//   decoded_mem_read_enable  current instruction is a load
//   decoded_mem_write_enable current instruction is a store
//   decoded_ret              current instruction is RET
//   lsu_busy                 per-lane LSU request outstanding
//   next_pc                  flattened per-lane next PC, lane i at [i*PC_BITS +: PC_BITS]
//   core_state               IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5 UPDATE=6 DONE=7
//   current_pc               issue PC
//   active_mask              lanes executing the current instruction
//   done                     all live threads have returned
//   diverge_count            (SIMT_DIVERGENCE_STATS_EN only) divergent issue count
// -----------------------------------------------------------------------------
module simt_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    input  logic                                 fetch_valid,
    input  logic                                 decoded_mem_read_enable,
    input  logic                                 decoded_mem_write_enable,
    input  logic                                 decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]         lsu_busy,
    input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc,
    output logic [2:0]                           core_state,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic [THREADS_PER_BLOCK-1:0]         active_mask,
    output logic                                 done
`ifdef SIMT_DIVERGENCE_STATS_EN
    ,
    output logic [15:0]                          diverge_count
`endif
);

    localparam int T   = THREADS_PER_BLOCK;
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
    localparam logic [TCW-1:0] T_MAX = TCW'(THREADS_PER_BLOCK);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Registered state
    state_t             state_r;
    logic [PC_BITS-1:0] current_pc_r;
    logic [T-1:0]       active_mask_r;
    logic               done_r;
    logic [TCW-1:0]     n_r;
    logic [PC_BITS-1:0] pc_r [T];
    logic [T-1:0]       fin_r;

    // Next-state values
    state_t             state_s;
    logic [PC_BITS-1:0] current_pc_s;
    logic [T-1:0]       active_mask_s;
    logic               done_s;
    logic [TCW-1:0]     n_s;
    logic [PC_BITS-1:0] pc_s [T];
    logic [T-1:0]       fin_s;

    // Post-update view used by the min-PC selection
    logic [PC_BITS-1:0] pc_upd_s [T];
    logic [T-1:0]       fin_upd_s;
    logic [T-1:0]       live_s;
    logic [T-1:0]       sel_mask_s;
    logic [PC_BITS-1:0] min_pc_s;
    logic               any_live_s;
    logic               take_s;

    logic [TCW-1:0]     tc_clamped_s;
    logic               mem_s;

    // Lanes 0..n-1 set.
    function automatic logic [T-1:0] lanes_below(input logic [TCW-1:0] n);
        logic [T-1:0] m;
        m = '0;
        for (int i = 0; i < T; i++) begin
            m[i] = (TCW'(i) < n);
        end
        return m;
    endfunction

    assign tc_clamped_s = (thread_count > T_MAX) ? T_MAX : thread_count;
    assign mem_s        = decoded_mem_read_enable | decoded_mem_write_enable;

    // Post-update lane state and min-PC selection over live lanes.
    always_comb begin
        pc_upd_s   = pc_r;
        fin_upd_s  = fin_r;
        min_pc_s   = '0;
        any_live_s = 1'b0;
        take_s     = 1'b0;
        sel_mask_s = '0;
        for (int i = 0; i < T; i++) begin
            if (active_mask_r[i]) begin
                if (decoded_ret) begin
                    fin_upd_s[i] = 1'b1;
                end else begin
                    pc_upd_s[i] = next_pc[i*PC_BITS +: PC_BITS];
                end
            end else begin
                pc_upd_s[i] = pc_r[i];
            end
        end
        live_s = lanes_below(n_r) & ~fin_upd_s;
        // First live lane seeds the minimum; later lanes replace it only if
        // strictly lower, so ties do not depend on lane order.
        for (int i = 0; i < T; i++) begin
            take_s     = live_s[i] && (!any_live_s || (pc_upd_s[i] < min_pc_s));
            min_pc_s   = take_s ? pc_upd_s[i] : min_pc_s;
            any_live_s = any_live_s | live_s[i];
        end
        for (int i = 0; i < T; i++) begin
            sel_mask_s[i] = live_s[i] && (pc_upd_s[i] == min_pc_s);
        end
    end

    // Next-state and next-output logic of the control FSM.
    always_comb begin
        state_s       = state_r;
        current_pc_s  = current_pc_r;
        active_mask_s = active_mask_r;
        done_s        = done_r;
        n_s           = n_r;
        pc_s          = pc_r;
        fin_s         = fin_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    n_s          = tc_clamped_s;
                    pc_s         = '{default: '0};
                    fin_s        = '0;
                    current_pc_s = '0;
                    if (tc_clamped_s == '0) begin
                        state_s       = S_DONE;
                        done_s        = 1'b1;
                        active_mask_s = '0;
                    end else begin
                        state_s       = S_FETCH;
                        active_mask_s = lanes_below(tc_clamped_s);
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH:   state_s = fetch_valid ? S_DECODE : S_FETCH;
            S_DECODE:  state_s = S_REQUEST;
            S_REQUEST: state_s = S_WAIT;
            // Only lanes taking part in the instruction can hold up WAIT.
            S_WAIT:    state_s = (mem_s && ((lsu_busy & active_mask_r) != '0)) ? S_WAIT : S_EXECUTE;
            S_EXECUTE: state_s = S_UPDATE;
            S_UPDATE: begin
                pc_s  = pc_upd_s;
                fin_s = fin_upd_s;
                if (any_live_s) begin
                    state_s       = S_FETCH;
                    current_pc_s  = min_pc_s;
                    active_mask_s = sel_mask_s;
                end else begin
                    state_s       = S_DONE;
                    done_s        = 1'b1;
                    active_mask_s = '0;
                end
            end
            S_DONE:    state_s = S_DONE;
            default: begin
                state_s       = S_IDLE;
                active_mask_s = '0;
                done_s        = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            current_pc_r  <= '0;
            active_mask_r <= '0;
            done_r        <= 1'b0;
            n_r           <= '0;
            pc_r          <= '{default: '0};
            fin_r         <= '0;
        end else begin
            state_r       <= state_s;
            current_pc_r  <= current_pc_s;
            active_mask_r <= active_mask_s;
            done_r        <= done_s;
            n_r           <= n_s;
            pc_r          <= pc_s;
            fin_r         <= fin_s;
        end
    end

    assign core_state  = state_r;
    assign current_pc  = current_pc_r;
    assign active_mask = active_mask_r;
    assign done        = done_r;

`ifdef SIMT_DIVERGENCE_STATS_EN
    logic        div_inc_s;
    logic [15:0] diverge_count_r;

    // A divergent issue is an UPDATE that returns to FETCH with fewer lanes
    // than are still live.
    assign div_inc_s = (state_r == S_UPDATE) && any_live_s && (sel_mask_s != live_s);

    // Saturating divergence counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            diverge_count_r <= 16'd0;
        end else if (div_inc_s && (diverge_count_r != 16'hFFFF)) begin
            diverge_count_r <= diverge_count_r + 16'd1;
        end else begin
            diverge_count_r <= diverge_count_r;
        end
    end

    assign diverge_count = diverge_count_r;
`endif

endmodule

// File: tb/tb_simt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_simt_scheduler
//
// Table-driven bench for simt_scheduler (THREADS_PER_BLOCK=4, PC_BITS=8).
// Each table record is one instruction: the per-lane next_pc and RET flag to
// present, plus the hand-computed issue PC, mask and done expected once the
// instruction has retired. Hand-written sequences cover LSU wait, clamping,
// empty blocks and reset in the middle of WAIT.
// -----------------------------------------------------------------------------
module tb_simt_scheduler;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_EXECUTE = 3'd5;
    localparam logic [2:0] ST_UPDATE  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  thread_count;
    logic        fetch_valid;
    logic        decoded_mem_read_enable;
    logic        decoded_mem_write_enable;
    logic        decoded_ret;
    logic [3:0]  lsu_busy;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic [3:0]  active_mask;
    logic        done;
`ifdef SIMT_DIVERGENCE_STATS_EN
    logic [15:0] diverge_count;
`endif

    simt_scheduler #(
        .THREADS_PER_BLOCK(4),
        .PC_BITS(8)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .thread_count             (thread_count),
        .fetch_valid              (fetch_valid),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .decoded_ret              (decoded_ret),
        .lsu_busy                 (lsu_busy),
        .next_pc                  (next_pc),
        .core_state               (core_state),
        .current_pc               (current_pc),
        .active_mask              (active_mask),
        .done                     (done)
`ifdef SIMT_DIVERGENCE_STATS_EN
        ,
        .diverge_count            (diverge_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] npc;       // {lane3, lane2, lane1, lane0}
        logic        ret;
        logic [7:0]  exp_pc;
        logic [3:0]  exp_mask;
        logic        exp_done;
    } vec_t;

    vec_t tbl [16];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset                    = 1'b1;
        start                    = 1'b0;
        thread_count             = 3'd0;
        fetch_valid              = 1'b0;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_ret              = 1'b0;
        lsu_busy                 = 4'h0;
        next_pc                  = 32'h0;
        step();
        step();
        reset = 1'b0;
        check("reset_state", {29'd0, core_state}, {29'd0, ST_IDLE});
        check("reset_pc",    {24'd0, current_pc}, 32'd0);
        check("reset_mask",  {28'd0, active_mask}, 32'd0);
        check("reset_done",  {31'd0, done}, 32'd0);
    endtask

    task automatic do_start(input logic [2:0] tc, input logic [3:0] exp_mask,
                            input logic [2:0] exp_state, input logic exp_done);
        start        = 1'b1;
        thread_count = tc;
        step();
        start = 1'b0;
        check($sformatf("start_state_tc%0d", tc), {29'd0, core_state}, {29'd0, exp_state});
        check($sformatf("start_pc_tc%0d", tc),    {24'd0, current_pc}, 32'd0);
        check($sformatf("start_mask_tc%0d", tc),  {28'd0, active_mask}, {28'd0, exp_mask});
        check($sformatf("start_done_tc%0d", tc),  {31'd0, done}, {31'd0, exp_done});
    endtask

    // Run one non-memory instruction from FETCH to the next FETCH or DONE.
    task automatic apply(input vec_t v, input int idx);
        int cyc;
        next_pc     = v.npc;
        decoded_ret = v.ret;
        fetch_valid = 1'b1;
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            cyc++;
            if (core_state == ST_FETCH || core_state == ST_DONE) break;
        end
        check($sformatf("latency[%0d]", idx), cyc, 32'd6);
        check($sformatf("state[%0d]", idx), {29'd0, core_state},
              v.exp_done ? {29'd0, ST_DONE} : {29'd0, ST_FETCH});
        check($sformatf("pc[%0d]", idx),   {24'd0, current_pc}, {24'd0, v.exp_pc});
        check($sformatf("mask[%0d]", idx), {28'd0, active_mask}, {28'd0, v.exp_mask});
        check($sformatf("done[%0d]", idx), {31'd0, done}, {31'd0, v.exp_done});
        decoded_ret = 1'b0;
    endtask

    // Step from FETCH into WAIT and count WAIT cycles; optionally drop
    // lsu_busy once a given number of WAIT cycles has been observed.
    task automatic count_wait(input int release_at, output int wait_cycles);
        fetch_valid = 1'b1;
        step();
        step();
        step();
        wait_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (core_state != ST_WAIT) break;
            wait_cycles++;
            if (wait_cycles == release_at) lsu_busy = 4'h0;
            step();
        end
    endtask

    initial begin
        int wc;

        // Scenario A: uniform run, RET at pc 3.
        tbl[0]  = '{32'h01010101, 1'b0, 8'd1, 4'hF, 1'b0};
        tbl[1]  = '{32'h02020202, 1'b0, 8'd2, 4'hF, 1'b0};
        tbl[2]  = '{32'h03030303, 1'b0, 8'd3, 4'hF, 1'b0};
        tbl[3]  = '{32'h00000000, 1'b1, 8'd3, 4'h0, 1'b1};
        // Scenario B: split at pc 2, reconverge at pc 5.
        tbl[4]  = '{32'h01010101, 1'b0, 8'd1, 4'hF, 1'b0};
        tbl[5]  = '{32'h02020202, 1'b0, 8'd2, 4'hF, 1'b0};
        tbl[6]  = '{32'h03030505, 1'b0, 8'd3, 4'hC, 1'b0};
        tbl[7]  = '{32'h04040909, 1'b0, 8'd4, 4'hC, 1'b0};
        tbl[8]  = '{32'h05050909, 1'b0, 8'd5, 4'hF, 1'b0};
        tbl[9]  = '{32'h00000000, 1'b1, 8'd5, 4'h0, 1'b1};
        // Scenario C: lane 1 returns alone, others continue through a PC wrap.
        tbl[10] = '{32'h02020102, 1'b0, 8'd1, 4'h2, 1'b0};
        tbl[11] = '{32'h00000000, 1'b1, 8'd2, 4'hD, 1'b0};
        tbl[12] = '{32'h03030903, 1'b0, 8'd3, 4'hD, 1'b0};
        tbl[13] = '{32'hFFFF09FF, 1'b0, 8'hFF, 4'hD, 1'b0};
        tbl[14] = '{32'h00000900, 1'b0, 8'd0, 4'hD, 1'b0};
        tbl[15] = '{32'h00000000, 1'b1, 8'd0, 4'h0, 1'b1};

        for (int k = 0; k < 16; k++) begin
            if (k == 0 || k == 4 || k == 10) begin
                do_reset();
                do_start(3'd4, 4'hF, ST_FETCH, 1'b0);
            end
            apply(tbl[k], k);
`ifdef SIMT_DIVERGENCE_STATS_EN
            if (k == 9) check("diverge_count", {16'd0, diverge_count}, 32'd2);
`endif
        end

        // DONE holds and ignores start.
        start        = 1'b1;
        thread_count = 3'd4;
        step();
        step();
        start = 1'b0;
        check("done_hold_state", {29'd0, core_state}, {29'd0, ST_DONE});
        check("done_hold_done",  {31'd0, done}, 32'd1);
        check("done_hold_pc",    {24'd0, current_pc}, 32'd0);

        // Empty block and clamped thread count.
        do_reset();
        do_start(3'd0, 4'h0, ST_DONE, 1'b1);
        do_reset();
        do_start(3'd7, 4'hF, ST_FETCH, 1'b0);

        // Load with lane 2 busy: WAIT lasts three cycles, then EXECUTE.
        do_reset();
        do_start(3'd4, 4'hF, ST_FETCH, 1'b0);
        decoded_mem_read_enable = 1'b1;
        lsu_busy                = 4'b0100;
        next_pc                 = 32'h01010101;
        count_wait(3, wc);
        check("wait_len_n4", wc, 32'd3);
        check("wait_exit_n4", {29'd0, core_state}, {29'd0, ST_EXECUTE});
        step();
        check("after_exec_n4", {29'd0, core_state}, {29'd0, ST_UPDATE});
        step();
        check("load_next_pc", {24'd0, current_pc}, 32'd1);
        check("load_next_mask", {28'd0, active_mask}, 32'hF);
        decoded_mem_read_enable = 1'b0;

        // Store with N=2: busy lane 2 is inactive, WAIT lasts one cycle.
        // start stays high throughout and must be ignored outside IDLE.
        do_reset();
        do_start(3'd2, 4'h3, ST_FETCH, 1'b0);
        start                    = 1'b1;
        thread_count             = 3'd4;
        decoded_mem_write_enable = 1'b1;
        lsu_busy                 = 4'b0100;
        count_wait(99, wc);
        check("wait_len_n2", wc, 32'd1);
        check("wait_exit_n2", {29'd0, core_state}, {29'd0, ST_EXECUTE});
        check("mask_n2", {28'd0, active_mask}, 32'h3);
        start                    = 1'b0;
        decoded_mem_write_enable = 1'b0;
        lsu_busy                 = 4'h0;

        // Reset while in WAIT, then a normal run from pc 0.
        do_reset();
        do_start(3'd4, 4'hF, ST_FETCH, 1'b0);
        decoded_mem_read_enable = 1'b1;
        lsu_busy                = 4'hF;
        fetch_valid             = 1'b1;
        step();
        step();
        step();
        check("in_wait", {29'd0, core_state}, {29'd0, ST_WAIT});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_wait_state", {29'd0, core_state}, {29'd0, ST_IDLE});
        check("rst_wait_done",  {31'd0, done}, 32'd0);
        check("rst_wait_pc",    {24'd0, current_pc}, 32'd0);
        check("rst_wait_mask",  {28'd0, active_mask}, 32'd0);
        decoded_mem_read_enable = 1'b0;
        lsu_busy                = 4'h0;
        fetch_valid             = 1'b0;
        do_start(3'd4, 4'hF, ST_FETCH, 1'b0);
        // FETCH holds while fetch_valid is low.
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("fetch_hold[%0d]", c), {29'd0, core_state}, {29'd0, ST_FETCH});
        end
        apply(tbl[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
